// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control and state bundle for pc_sequencer (align_error present under PC_ALIGN_CHECK_EN)
interface pc_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               pc_write;
    logic               pc_write_cond;
    logic               zero;
    logic [1:0]         pc_source;
    logic               latch_target;
    logic [31:0]        adder_result;
    logic [25:0]        instr_index;
    logic               halt;
    logic [31:0]        pc;
    logic [31:0]        target_q;
    logic [COUNT_W-1:0] update_count;
    logic               halted;
`ifdef PC_ALIGN_CHECK_EN
    logic               align_error;
`endif

    modport slave (
        input  pc_write, pc_write_cond, zero, pc_source, latch_target,
               adder_result, instr_index, halt,
        output pc, target_q, update_count, halted
`ifdef PC_ALIGN_CHECK_EN
        , output align_error
`endif
    );

    modport master (
        output pc_write, pc_write_cond, zero, pc_source, latch_target,
               adder_result, instr_index, halt,
        input  pc, target_q, update_count, halted
`ifdef PC_ALIGN_CHECK_EN
        , input align_error
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle MIPS PC register, target latch, halt and update counter (option: PC_ALIGN_CHECK_EN)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 16
) (
    input  logic          clock,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t             state;
    logic [31:0]        pc_q;
    logic [31:0]        target_r;
    logic [COUNT_W-1:0] count_q;
    logic               halted_q;
    logic [31:0]        next_pc;
    logic               commit;
`ifdef PC_ALIGN_CHECK_EN
    logic               align_q;
`endif

    always_comb begin
        next_pc = pc_q;
        case (bus.pc_source)
            2'd0:    next_pc = bus.adder_result;
            2'd1:    next_pc = target_r;
            2'd2:    next_pc = {pc_q[31:28], bus.instr_index, 2'b00};
            default: next_pc = pc_q;
        endcase
    end

    // pc_source 3 is a non-update: it neither moves pc nor counts.
    assign commit = (state == RUN)
                  && (bus.pc_write || (bus.pc_write_cond && bus.zero))
                  && (bus.pc_source != 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            target_r <= 32'h0;
            count_q  <= '0;
            halted_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_q  <= 1'b0;
`endif
        end else if (state == RUN) begin
            if (bus.latch_target)
                target_r <= bus.adder_result;
            if (commit) begin
`ifdef PC_ALIGN_CHECK_EN
                if (next_pc[1:0] != 2'b00) begin
                    align_q  <= 1'b1;
                    state    <= HALTED;
                    halted_q <= 1'b1;
                end else begin
                    pc_q    <= next_pc;
                    count_q <= count_q + 1'b1;
                end
`else
                pc_q    <= next_pc;
                count_q <= count_q + 1'b1;
`endif
            end
            // A halt on the same edge as a commit still lets that commit land.
            if (bus.halt) begin
                state    <= HALTED;
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.target_q     = target_r;
    assign bus.update_count = count_q;
    assign bus.halted       = halted_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.align_error  = align_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer (covers PC_ALIGN_CHECK_EN when defined)
module tb_pc_sequencer;
    localparam int CW = 4;

    typedef struct {
        logic        rst, pw, pwc, z;
        logic [1:0]  src;
        logic        lt;
        logic [31:0] ar;
        logic [25:0] idx;
        logic        h;
        logic [31:0] epc, et;
        logic [CW-1:0] ec;
        logic        eh;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    pc_sequencer_if #(.COUNT_W(CW)) bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(int rst, int pw, int pwc, int z, int src, int lt,
                                int ar, int idx, int h, int epc, int et, int ec, int eh);
        vec_t v;
        v.rst = rst[0]; v.pw = pw[0]; v.pwc = pwc[0]; v.z = z[0];
        v.src = src[1:0]; v.lt = lt[0]; v.ar = ar; v.idx = idx[25:0]; v.h = h[0];
        v.epc = epc; v.et = et; v.ec = ec[CW-1:0]; v.eh = eh[0];
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic pw, logic pwc, logic z, logic [1:0] src,
                         logic lt, logic [31:0] ar, logic [25:0] idx, logic h);
        reset = rst; bus.pc_write = pw; bus.pc_write_cond = pwc; bus.zero = z;
        bus.pc_source = src; bus.latch_target = lt; bus.adder_result = ar;
        bus.instr_index = idx; bus.halt = h;
    endtask

    initial begin
        //            rst pw pwc z src lt ar            idx  h   pc            target  cnt halted
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0,    0, 0,            0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0,    0, 0,            0,      0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h55,   0,    0, 0,            0,      0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4,            0,    0, 4,            0,      1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8,            0,    0, 8,            0,      2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 12,           0,    0, 12,           0,      3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h10,       0,    0, 32'h10,       0,      4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h40,       0,    0, 32'h10,       32'h40, 4, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 32'h44,       0,    0, 32'h10,       32'h40, 4, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 32'h44,       0,    0, 32'h40,       32'h40, 5, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1000_0008, 0,   0, 32'h1000_0008, 32'h40, 6, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 0, 0,            26'h10, 0, 32'h1000_0040, 32'h40, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80,       0,    0, 32'h1000_0040, 32'h80, 7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h90,       0,    0, 32'h80,       32'h90, 8, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3, 0, 32'h200,      0,    0, 32'h80,       32'h90, 8, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h24,       0,    1, 32'h24,       32'h90, 9, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'h100,      0,    0, 32'h24,       32'h90, 9, 1));
        vecs.push_back(mk(0, 1, 1, 1, 2, 0, 0,            26'h3, 1, 32'h24,       32'h90, 9, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 32'h300,      0,    1, 0,            0,      0, 0));

        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].pw, vecs[i].pwc, vecs[i].z, vecs[i].src,
                  vecs[i].lt, vecs[i].ar, vecs[i].idx, vecs[i].h);
            @(posedge clock); #1;
            check($sformatf("v%0d_pc", i),     bus.pc,                  vecs[i].epc);
            check($sformatf("v%0d_target", i), bus.target_q,            vecs[i].et);
            check($sformatf("v%0d_count", i),  32'(bus.update_count),   32'(vecs[i].ec));
            check($sformatf("v%0d_halted", i), 32'(bus.halted),         32'(vecs[i].eh));
        end

        // Counter wrap: 17 commits on a 4-bit counter.
        for (int i = 1; i <= 17; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'(4 * i), 26'h0, 1'b0);
            @(posedge clock); #1;
            if (i == 15) check("wrap_c15", 32'(bus.update_count), 32'd15);
            if (i == 16) check("wrap_c16", 32'(bus.update_count), 32'd0);
        end
        check("wrap_c17", 32'(bus.update_count), 32'd1);
        check("wrap_pc",  bus.pc, 32'h44);

        // Misaligned commit.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h22, 26'h0, 1'b0);
        @(posedge clock); #1;
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc",     bus.pc, 32'h44);
        check("mis_count",  32'(bus.update_count), 32'd1);
        check("mis_halted", 32'(bus.halted), 32'd1);
        check("mis_align",  32'(bus.align_error), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 1'b0);
        @(posedge clock); #1;
        check("mis_rst_align",  32'(bus.align_error), 32'd0);
        check("mis_rst_halted", 32'(bus.halted), 32'd0);
`else
        check("mis_pc",     bus.pc, 32'h22);
        check("mis_count",  32'(bus.update_count), 32'd2);
        check("mis_halted", 32'(bus.halted), 32'd0);
`endif

        // Halt with no commit, then writes are ignored.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 1'b1);
        @(posedge clock); #1;
        check("halt_only", 32'(bus.halted), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h500, 26'h0, 1'b0);
        @(posedge clock); #1;
        check("halt_hold_target", 32'(bus.target_q == 32'h500), 32'd0);
        check("halt_hold_pc",     32'(bus.pc == 32'h500), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
